scandoubler: RTL and testbench

SCANDOUBLER -- requirements
Module: scandoubler

---
 rtl/scandoubler.sv | 158 +++++++++++++++
 tb/tb_scandoubler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scandoubler.sv
// Line-doubling scan converter: captures each 15 kHz input line (sampled at clk/2) into one
// bank of a two-bank line buffer and replays the previous line twice at clk rate.
module scandoubler #(
  parameter int unsigned HMAX_BITS   = 10,
  parameter int unsigned HSYNC_WIDTH = 56
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       scanlines,
  input  logic [1:0] r_in,
  input  logic [1:0] g_in,
  input  logic [1:0] b_in,
  input  logic       bright_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [1:0] r_out,
  output logic [1:0] g_out,
  output logic [1:0] b_out,
  output logic       bright_out,
  output logic       hsync_out,
  output logic       vsync_out
);

  localparam int unsigned          Depth   = 2 ** HMAX_BITS;
  localparam logic [HMAX_BITS-1:0] CntMax  = '1;
  localparam logic [HMAX_BITS-1:0] CntOne  = {{(HMAX_BITS-1){1'b0}}, 1'b1};
  localparam logic [HMAX_BITS:0]   HsWidth = HSYNC_WIDTH[HMAX_BITS:0];

  logic [6:0] buf_mem [2*Depth];

  logic                 ph_q, ph_d;
  logic                 hs_prev_q, hs_prev_d;
  logic                 wb_q, wb_d;
  logic                 seen_q, seen_d;
  logic                 odd_q, odd_d;
  logic                 en_q, en_d;
  logic                 sl_q, sl_d;
  logic [HMAX_BITS-1:0] wcnt_q, wcnt_d;
  logic [HMAX_BITS-1:0] wlen_q, wlen_d;
  logic [HMAX_BITS-1:0] rcnt_q, rcnt_d;
  logic [HMAX_BITS-1:0] waddr;
  logic                 line_start;
  logic                 rd_wrap;

  // First pipeline stage: buffer read data plus everything that must stay aligned with it.
  logic [6:0] rd_q;
  logic       act1_q, dark1_q, en1_q, hs1_q, phs1_q, vs1_q;
  logic [6:0] pass1_q;

  logic [6:0] pix_q, pix_d;
  logic       hs_q, hs_d;
  logic       vs_q;

  always_comb begin
    line_start = ph_q & hs_prev_q & ~hsync_in;
    rd_wrap    = (rcnt_q == wlen_q - CntOne);
    ph_d       = ~ph_q;
    hs_prev_d  = ph_q ? hsync_in : hs_prev_q;
    wb_d       = wb_q;
    seen_d     = seen_q;
    en_d       = en_q;
    sl_d       = sl_q;
    wcnt_d     = wcnt_q;
    wlen_d     = wlen_q;
    waddr      = wcnt_q;
    rcnt_d     = rd_wrap ? '0 : rcnt_q + CntOne;
    odd_d      = rd_wrap ? ~odd_q : odd_q;
    if (line_start) begin
      wb_d   = ~wb_q;
      waddr  = '0;
      wcnt_d = CntOne;
      // The line cut by a reset is never shown: only lines bounded by two starts count.
      wlen_d = seen_q ? wcnt_q : '0;
      seen_d = 1'b1;
      en_d   = enable;
      sl_d   = scanlines;
      rcnt_d = '0;
      odd_d  = 1'b0;
    end else if (ph_q && (wcnt_q != CntMax)) begin
      wcnt_d = wcnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (ph_q && !rst) begin
      buf_mem[{wb_d, waddr}] <= {r_in, g_in, b_in, bright_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q      <= 1'b0;
      hs_prev_q <= 1'b1;
      wb_q      <= 1'b0;
      seen_q    <= 1'b0;
      odd_q     <= 1'b0;
      en_q      <= 1'b1;
      sl_q      <= 1'b0;
      wcnt_q    <= '0;
      wlen_q    <= '0;
      rcnt_q    <= '0;
      rd_q      <= '0;
      act1_q    <= 1'b0;
      dark1_q   <= 1'b0;
      en1_q     <= 1'b1;
      hs1_q     <= 1'b1;
      phs1_q    <= 1'b1;
      vs1_q     <= 1'b1;
      pass1_q   <= '0;
      pix_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else begin
      ph_q      <= ph_d;
      hs_prev_q <= hs_prev_d;
      wb_q      <= wb_d;
      seen_q    <= seen_d;
      odd_q     <= odd_d;
      en_q      <= en_d;
      sl_q      <= sl_d;
      wcnt_q    <= wcnt_d;
      wlen_q    <= wlen_d;
      rcnt_q    <= rcnt_d;
      rd_q      <= buf_mem[{~wb_q, rcnt_q}];
      act1_q    <= (wlen_q != '0);
      dark1_q   <= sl_q & odd_q;
      en1_q     <= en_q;
      hs1_q     <= ({1'b0, rcnt_q} >= HsWidth);
      phs1_q    <= hsync_in;
      vs1_q     <= vsync_in;
      pass1_q   <= {r_in, g_in, b_in, bright_in};
      pix_q     <= pix_d;
      hs_q      <= hs_d;
      vs_q      <= vs1_q;
    end
  end

  always_comb begin
    pix_d = '0;
    hs_d  = 1'b1;
    if (!en1_q) begin
      pix_d = pass1_q;
      hs_d  = phs1_q;
    end else if (act1_q) begin
      pix_d = dark1_q ? {1'b0, rd_q[6], 1'b0, rd_q[4], 1'b0, rd_q[2], 1'b0} : rd_q;
      hs_d  = hs1_q;
    end
  end

  assign r_out      = pix_q[6:5];
  assign g_out      = pix_q[4:3];
  assign b_out      = pix_q[2:1];
  assign bright_out = pix_q[0];
  assign hsync_out  = hs_q;
  assign vsync_out  = vs_q;

endmodule

// File: tb/tb_scandoubler.sv
// Directed bench for scandoubler: doubling, scanlines, passthrough, saturation, short lines
// and reset behaviour, with expected values computed from the input patterns.
module tb_scandoubler;
  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       scanlines;
  logic [1:0] r_in, g_in, b_in;
  logic       bright_in, hsync_in, vsync_in;
  logic [1:0] r_out, g_out, b_out;
  logic       bright_out, hsync_out, vsync_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scandoubler #(
    .HMAX_BITS  (10),
    .HSYNC_WIDTH(56)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .scanlines (scanlines),
    .r_in      (r_in),
    .g_in      (g_in),
    .b_in      (b_in),
    .bright_in (bright_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .r_out     (r_out),
    .g_out     (g_out),
    .b_out     (b_out),
    .bright_out(bright_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input logic [6:0] v);
    {r_in, g_in, b_in, bright_in} = v;
  endtask

  function automatic logic [6:0] out_pix();
    return {r_out, g_out, b_out, bright_out};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    set_pix(7'h00);
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // Each sample is held for 2 clk; pixel = sample index mod 128, xored with 0x2a from xor_from on.
  task automatic drive_lines(input int nlines, input int len, input int hlow, input int xor_from);
    logic [31:0] kk;
    for (int l = 0; l < nlines; l++) begin
      for (int k = 0; k < len; k++) begin
        kk = k;
        hsync_in = (k < hlow) ? 1'b0 : 1'b1;
        set_pix(kk[6:0] ^ ((k >= xor_from) ? 7'h2a : 7'h00));
        tick();
        tick();
      end
    end
  endtask

  task automatic wait_fall(input int budget, output int cycles);
    cycles = 0;
    while (hsync_out !== 1'b0 && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    scanlines = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    set_pix(7'h7f);
    repeat (3) tick();
    total++;
    if (out_pix() !== 7'h00) begin
      bad++; $display("FAIL reset_pix got=%h exp=00", out_pix());
    end
    total++;
    if (hsync_out !== 1'b1) begin
      bad++; $display("FAIL reset_hsync got=%b exp=1", hsync_out);
    end
    total++;
    if (vsync_out !== 1'b1) begin
      bad++; $display("FAIL reset_vsync got=%b exp=1", vsync_out);
    end
  endtask

  task automatic test_doubled();
    int c;
    logic [31:0] idx;
    logic exp_hs;
    enable = 1'b1;
    scanlines = 1'b0;
    do_reset();
    fork
      drive_lines(3, 768, 64, 4096);
      begin
        wait_fall(4000, c);
        total++;
        if (c >= 4000) begin
          bad++; $display("FAIL doubled_start got=timeout exp=hsync_out fall");
        end else begin
          for (int n = 0; n < 1536; n++) begin
            idx = n % 768;
            exp_hs = (idx < 56) ? 1'b0 : 1'b1;
            total++;
            if (out_pix() !== idx[6:0]) begin
              bad++; $display("FAIL doubled_pix n=%0d got=%h exp=%h", n, out_pix(), idx[6:0]);
            end
            total++;
            if (hsync_out !== exp_hs) begin
              bad++; $display("FAIL doubled_hsync n=%0d got=%b exp=%b", n, hsync_out, exp_hs);
            end
            tick();
          end
        end
      end
    join
  endtask

  task automatic test_scanlines();
    int c;
    logic [31:0] idx;
    logic [6:0] v, exp_v;
    logic exp_hs;
    enable = 1'b1;
    scanlines = 1'b1;
    do_reset();
    fork
      drive_lines(3, 768, 64, 4096);
      begin
        wait_fall(4000, c);
        total++;
        if (c >= 4000) begin
          bad++; $display("FAIL scan_start got=timeout exp=hsync_out fall");
        end else begin
          for (int n = 0; n < 1536; n++) begin
            idx = n % 768;
            v = idx[6:0];
            exp_v = (n >= 768) ? {1'b0, v[6], 1'b0, v[4], 1'b0, v[2], 1'b0} : v;
            exp_hs = (idx < 56) ? 1'b0 : 1'b1;
            total++;
            if (out_pix() !== exp_v) begin
              bad++; $display("FAIL scan_pix n=%0d got=%h exp=%h", n, out_pix(), exp_v);
            end
            total++;
            if (hsync_out !== exp_hs) begin
              bad++; $display("FAIL scan_hsync n=%0d got=%b exp=%b", n, hsync_out, exp_hs);
            end
            tick();
          end
        end
      end
    join
    scanlines = 1'b0;
  endtask

  task automatic test_vsync();
    logic cur, prev;
    prev = 1'b1;
    enable = 1'b1;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      cur = 1'($urandom);
      vsync_in = cur;
      tick();
      if (i > 0) begin
        total++;
        if (vsync_out !== prev) begin
          bad++; $display("FAIL vsync_delay i=%0d got=%b exp=%b", i, vsync_out, prev);
        end
      end
      prev = cur;
    end
  endtask

  task automatic test_passthrough();
    logic [8:0] cur, prev, got;
    prev = '0;
    enable = 1'b0;
    hsync_in = 1'b1;
    repeat (4) tick();
    hsync_in = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 60; i++) begin
      cur = 9'($urandom);
      if (i >= 40) begin
        // hsync held high: raising enable mid-line must not leave passthrough yet
        cur[1] = 1'b1;
        enable = 1'b1;
      end
      {r_in, g_in, b_in, bright_in, hsync_in, vsync_in} = cur;
      tick();
      got = {r_out, g_out, b_out, bright_out, hsync_out, vsync_out};
      if (i > 0) begin
        total++;
        if (got !== prev) begin
          bad++; $display("FAIL pass_delay i=%0d got=%h exp=%h", i, got, prev);
        end
      end
      prev = cur;
    end
    // Next line start switches to doubled mode; the line is shorter than the sync width.
    hsync_in = 1'b0;
    repeat (4) tick();
    hsync_in = 1'b1;
    repeat (6) tick();
    total++;
    if (hsync_out !== 1'b0) begin
      bad++; $display("FAIL mode_switch_hsync got=%b exp=0", hsync_out);
    end
  endtask

  task automatic test_saturate();
    int c;
    logic [31:0] idx;
    logic exp_hs;
    enable = 1'b1;
    do_reset();
    fork
      begin
        drive_lines(1, 1500, 64, 1023);
        drive_lines(1, 768, 64, 4096);
      end
      begin
        wait_fall(8000, c);
        total++;
        if (c >= 8000) begin
          bad++; $display("FAIL sat_start got=timeout exp=hsync_out fall");
        end else begin
          for (int n = 0; n < 1024; n++) begin
            idx = n % 1023;
            exp_hs = (idx < 56) ? 1'b0 : 1'b1;
            total++;
            if (out_pix() !== idx[6:0]) begin
              bad++; $display("FAIL sat_pix n=%0d got=%h exp=%h", n, out_pix(), idx[6:0]);
            end
            total++;
            if (hsync_out !== exp_hs) begin
              bad++; $display("FAIL sat_hsync n=%0d got=%b exp=%b", n, hsync_out, exp_hs);
            end
            tick();
          end
        end
      end
    join
  endtask

  task automatic test_short();
    int c;
    logic [31:0] idx;
    enable = 1'b1;
    do_reset();
    fork
      drive_lines(6, 40, 8, 4096);
      begin
        wait_fall(1000, c);
        total++;
        if (c >= 1000) begin
          bad++; $display("FAIL short_start got=timeout exp=hsync_out fall");
        end else begin
          for (int n = 0; n < 160; n++) begin
            idx = n % 40;
            total++;
            if (hsync_out !== 1'b0 ||
                $isunknown({r_out, g_out, b_out, bright_out, hsync_out, vsync_out})) begin
              bad++; $display("FAIL short_hsync n=%0d got=%b exp=0", n, hsync_out);
            end
            total++;
            if (out_pix() !== idx[6:0]) begin
              bad++; $display("FAIL short_pix n=%0d got=%h exp=%h", n, out_pix(), idx[6:0]);
            end
            tick();
          end
        end
      end
    join
  endtask

  task automatic test_reset_midline();
    int c;
    enable = 1'b1;
    scanlines = 1'b0;
    do_reset();
    fork
      drive_lines(4, 768, 64, 4096);
      begin
        repeat (2138) tick();
        rst = 1'b1;
        tick();
        total++;
        if (out_pix() !== 7'h00) begin
          bad++; $display("FAIL midrst_pix got=%h exp=00", out_pix());
        end
        total++;
        if (hsync_out !== 1'b1) begin
          bad++; $display("FAIL midrst_hsync got=%b exp=1", hsync_out);
        end
        total++;
        if (vsync_out !== 1'b1) begin
          bad++; $display("FAIL midrst_vsync got=%b exp=1", vsync_out);
        end
        rst = 1'b0;
        c = 0;
        while (hsync_out !== 1'b0 && c < 5000) begin
          total++;
          if (out_pix() !== 7'h00) begin
            bad++; $display("FAIL midrst_black c=%0d got=%h exp=00", c, out_pix());
          end
          tick();
          c++;
        end
        // The partial line cut by reset must not be shown; output resumes a full line later.
        total++;
        if (c >= 5000 || c < 1536) begin
          bad++; $display("FAIL midrst_resume got=%0d clk exp=1536..4999", c);
        end
      end
    join
  endtask

  initial begin
    enable = 1'b1;
    scanlines = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    set_pix(7'h00);
    test_reset();
    test_doubled();
    test_scanlines();
    test_vsync();
    test_passthrough();
    test_saturate();
    test_short();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
